// File: rtl/vend_payment_ctrl.sv
// rtl/vend_payment_ctrl.sv - coin credit, dispense handshake and change/refund front end
// Optional macro DISP_TIMEOUT_EN: refund full credit if dispense is not acknowledged in DISP_TIMEOUT cycles.
module vend_payment_ctrl #(
  parameter int CREDIT_W     = 8,
  parameter int PRICE        = 75,
  parameter int MAX_CREDIT   = 200,
  parameter int DISP_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                cancel,
  input  logic                dispense,
  output logic                dispense_req,
  output logic                payment_ok,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, REQUEST, CHANGE} state_t;

  localparam logic [CREDIT_W:0] PRICE_L = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_L   = (CREDIT_W+1)'(MAX_CREDIT);

  generate
    if (PRICE >= (1 << CREDIT_W) || MAX_CREDIT < PRICE || MAX_CREDIT >= (1 << CREDIT_W) ||
        DISP_TIMEOUT < 1) begin : g_bad_cfg
      $error("vend_payment_ctrl: inconsistent PRICE/MAX_CREDIT/CREDIT_W/DISP_TIMEOUT");
    end
  endgenerate

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_req_q, dispense_req_d;
  logic                payment_ok_q, payment_ok_d;
  logic                coin_reject_q, coin_reject_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
  logic                busy_q, busy_d;

`ifdef DISP_TIMEOUT_EN
  localparam int            TW       = $clog2(DISP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DISP_TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  logic [CREDIT_W:0]   coin_value;
  logic [CREDIT_W:0]   sum;
  logic                go_change;
  logic [CREDIT_W-1:0] payout;

  always_comb begin
    case (coin_code)
      2'b00:   coin_value = (CREDIT_W+1)'(5);
      2'b01:   coin_value = (CREDIT_W+1)'(10);
      2'b10:   coin_value = (CREDIT_W+1)'(25);
      default: coin_value = (CREDIT_W+1)'(100);
    endcase
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    dispense_req_d  = 1'b0;
    payment_ok_d    = 1'b0;
    coin_reject_d   = 1'b0;
    change_valid_d  = 1'b0;
    change_amount_d = change_amount_q;
    go_change       = 1'b0;
    payout          = '0;
    // One extra bit so a large coin on top of high credit cannot wrap.
    sum             = {1'b0, credit_q} + coin_value;
`ifdef DISP_TIMEOUT_EN
    tmo_cnt_d       = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (coin_valid) begin
          credit_d = coin_value[CREDIT_W-1:0];
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          go_change     = 1'b1;
          payout        = credit_q;
        end else begin
          if (coin_valid) begin
            if (sum <= MAX_L) credit_d = sum[CREDIT_W-1:0];
            else              coin_reject_d = 1'b1;
          end
          if ({1'b0, credit_q} >= PRICE_L) begin
            state_d        = REQUEST;
            dispense_req_d = 1'b1;
            payment_ok_d   = 1'b1;
`ifdef DISP_TIMEOUT_EN
            tmo_cnt_d      = '0;
`endif
          end
        end
      end
      REQUEST: begin
        coin_reject_d = coin_valid;
        if (dispense) begin
          go_change = 1'b1;
          payout    = credit_q - PRICE_L[CREDIT_W-1:0];
        end
`ifdef DISP_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          go_change = 1'b1;
          payout    = credit_q;
        end
`endif
        else begin
          dispense_req_d = 1'b1;
          payment_ok_d   = 1'b1;
`ifdef DISP_TIMEOUT_EN
          tmo_cnt_d      = tmo_cnt_q + 1'b1;
`endif
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A zero payout still passes through CHANGE, just without a pulse.
    if (go_change) begin
      state_d         = CHANGE;
      change_valid_d  = (payout != '0);
      change_amount_d = payout;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      dispense_req_q  <= 1'b0;
      payment_ok_q    <= 1'b0;
      coin_reject_q   <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      busy_q          <= 1'b0;
`ifdef DISP_TIMEOUT_EN
      tmo_cnt_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      dispense_req_q  <= dispense_req_d;
      payment_ok_q    <= payment_ok_d;
      coin_reject_q   <= coin_reject_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      busy_q          <= busy_d;
`ifdef DISP_TIMEOUT_EN
      tmo_cnt_q       <= tmo_cnt_d;
`endif
    end
  end

  assign dispense_req  = dispense_req_q;
  assign payment_ok    = payment_ok_q;
  assign coin_reject   = coin_reject_q;
  assign credit        = credit_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign busy          = busy_q;

endmodule
